// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath.
//   DefChannels / DefWordW : default lane count and word length
//   bit_cnt_w()            : width of a bit counter for a given word length
//                            (sizes each user's local bit_cnt_t)
//   serial_mode_e          : per-lane operation, ADD = x+y, SUB = x-y
package serial_arith_pkg;

    localparam int unsigned DefChannels = 4;
    localparam int unsigned DefWordW    = 16;

    // Width of a bit_cnt_t able to index bits 0..w-1 of a word.
    function automatic int unsigned bit_cnt_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } serial_mode_e;

endpackage

// File: rtl/serial_addsub_slice.sv
// One lane of the bit-serial adder/subtractor.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN (adds the ovf flop and port).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          synchronous clear of carry/mode (and ovf); sum holds
//   accept       an input bit is taken this cycle
//   first, last  accepted bit is bit 0 / bit WORD_W-1 of the word
//   x, y         operand bits, LSB first
//   sub          mode request, only used on the first bit
//   sum          registered result bit
//   ovf          signed overflow of the last completed word (optional)
module serial_addsub_slice
    import serial_arith_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic accept,
    input  logic first,
    input  logic last,
    input  logic x,
    input  logic y,
    input  logic sub,
    output logic sum
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic ovf
`endif
);

    serial_mode_e mode_q, mode_act;
    logic         carry_q, cin, y_eff, sum_d, cout;

    // On bit 0 the new mode takes effect immediately and doubles as the
    // carry-in, giving x + ~y + 1 for subtraction; the old carry is dropped.
    always_comb begin
        mode_act = first ? serial_mode_e'(sub) : mode_q;
        cin      = first ? sub : carry_q;
        y_eff    = y ^ (mode_act == SUB);
        sum_d    = x ^ y_eff ^ cin;
        cout     = (x & y_eff) | (x & cin) | (y_eff & cin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            mode_q  <= ADD;
            sum     <= 1'b0;
        end else if (clr) begin
            carry_q <= 1'b0;
            mode_q  <= ADD;
        end else if (accept) begin
            carry_q <= cout;
            mode_q  <= mode_act;
            sum     <= sum_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // On the MSB, cin is the carry into the sign bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (accept && last) begin
            ovf <= cin ^ cout;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/serial_addsub_array.sv
// Multi-channel bit-serial adder/subtractor on LSB-first two's-complement
// words. A shared bit counter frames words; each lane is a
// serial_addsub_slice. Latency is one cycle.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN (per-lane signed overflow).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous framing clear, priority over in_valid
//   in_valid    qualifies x, y, sub this cycle
//   x, y        operand bits per lane
//   sub         per-lane mode, sampled on bit 0: 1 = x-y, 0 = x+y
//   sum         registered result bits
//   out_valid   sum holds a freshly produced bit
//   out_first   sum holds bit 0 of a word
//   out_last    sum holds bit WORD_W-1 of a word
//   ovf         per-lane signed overflow (only with SERIAL_ADDSUB_OVF_EN)
module serial_addsub_array
    import serial_arith_pkg::*;
#(
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned WORD_W   = DefWordW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [CHANNELS-1:0] x,
    input  logic [CHANNELS-1:0] y,
    input  logic [CHANNELS-1:0] sub,
    output logic [CHANNELS-1:0] sum,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic [CHANNELS-1:0] ovf
`endif
);

    localparam int unsigned CntW = bit_cnt_w(WORD_W);
    typedef logic [CntW-1:0] bit_cnt_t;
    localparam bit_cnt_t LastIdx = bit_cnt_t'(WORD_W - 1);

    bit_cnt_t cnt_q, cnt_d;
    logic     first, last, accept;

    assign accept = in_valid & ~clr;

    always_comb begin
        first = (cnt_q == '0);
        last  = (cnt_q == LastIdx);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (in_valid) begin
            cnt_d = last ? '0 : cnt_q + bit_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            out_valid <= accept;
            out_first <= accept & first;
            out_last  <= accept & last;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        serial_addsub_slice u_slice (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .accept (accept),
            .first  (first),
            .last   (last),
            .x      (x[g]),
            .y      (y[g]),
            .sub    (sub[g]),
            .sum    (sum[g])
`ifdef SERIAL_ADDSUB_OVF_EN
            ,
            .ovf    (ovf[g])
`endif
        );
    end

endmodule

// File: tb/tb_serial_addsub_array.sv
module tb_serial_addsub_array;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [CH-1:0] x = '0, y = '0, sub = '0;
    logic [CH-1:0] sum;
    logic          out_valid, out_first, out_last;
    logic [CH-1:0] ovf_obs;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_addsub_array #(
        .CHANNELS (CH),
        .WORD_W   (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .sum       (sum),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf       (ovf_obs)
`endif
    );

`ifndef SERIAL_ADDSUB_OVF_EN
    assign ovf_obs = '0;
`endif

    // Reference: word-level result and signed overflow from plain arithmetic.
    function automatic logic [7:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        return s ? (a - b) : (a + b);
    endfunction

    function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic s);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r  = s ? (sa - sb) : (sa + sb);
        return (r > 127) || (r < -128);
    endfunction

    // Drives one word per lane, optionally with in_valid gaps after selected bits.
    // Leaves in_valid high so a following call runs back-to-back.
    task automatic drive_word(input logic [1:0][7:0] a, input logic [1:0][7:0] b,
                              input logic [1:0] s, input logic [7:0] gap_mask,
                              input int gap_len, output logic [1:0][7:0] got,
                              output logic [7:0] fpat, output logic [7:0] lpat,
                              output int vbad, output int gap_bad,
                              output logic [1:0] got_ovf);
        logic [1:0] hold;
        vbad    = 0;
        gap_bad = 0;
        got_ovf = '0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            x   = {a[1][i], a[0][i]};
            y   = {b[1][i], b[0][i]};
            sub = (i == 0) ? s : 2'($urandom);
            @(posedge clk);
            #1;
            got[0][i] = sum[0];
            got[1][i] = sum[1];
            fpat[i]   = out_first;
            lpat[i]   = out_last;
            if (out_valid !== 1'b1) vbad++;
            if (i == 7) got_ovf = ovf_obs;
            if (gap_mask[i] && gap_len > 0) begin
                hold = sum;
                for (int k = 0; k < gap_len; k++) begin
                    in_valid = 1'b0;
                    x   = 2'($urandom);
                    y   = 2'($urandom);
                    sub = 2'($urandom);
                    @(posedge clk);
                    #1;
                    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 ||
                        sum !== hold) gap_bad++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            x   = 2'($urandom);
            y   = 2'($urandom);
            sub = 2'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({sum, out_valid, out_first, out_last, ovf_obs} !== '0) begin
            fails++;
            $display("FAIL reset: got sum=%b v=%b f=%b l=%b ovf=%b, want all 0",
                     sum, out_valid, out_first, out_last, ovf_obs);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_add();
        logic [1:0][7:0] got;
        logic [7:0] fp, lp;
        int vb, gb;
        logic [1:0] go;
        drive_word({8'h5A, 8'h35}, {8'h21, 8'h0A}, 2'b00, 8'h00, 0, got, fp, lp, vb, gb, go);
        idle(2);
        tests_run++;
        if (got[0] !== ref_res(8'h35, 8'h0A, 1'b0)) begin
            fails++;
            $display("FAIL add_lane0: got %h want %h", got[0], ref_res(8'h35, 8'h0A, 1'b0));
        end
        tests_run++;
        if (got[1] !== ref_res(8'h5A, 8'h21, 1'b0)) begin
            fails++;
            $display("FAIL add_lane1: got %h want %h", got[1], ref_res(8'h5A, 8'h21, 1'b0));
        end
        tests_run++;
        if (fp !== 8'h01 || lp !== 8'h80 || vb !== 0) begin
            fails++;
            $display("FAIL add_flags: first=%b last=%b vbad=%0d want 00000001 10000000 0",
                     fp, lp, vb);
        end
`ifdef SERIAL_ADDSUB_OVF_EN
        tests_run++;
        if (go !== 2'b00) begin
            fails++;
            $display("FAIL add_ovf: got %b want 00", go);
        end
`endif
    endtask

    task automatic test_sub();
        logic [1:0][7:0] got;
        logic [7:0] fp, lp;
        int vb, gb;
        logic [1:0] go;
        drive_word({8'h10, 8'h10}, {8'h01, 8'h01}, 2'b10, 8'h00, 0, got, fp, lp, vb, gb, go);
        idle(1);
        tests_run++;
        if (got[1] !== 8'h0F || got[0] !== 8'h11) begin
            fails++;
            $display("FAIL sub_lanes: got l1=%h l0=%h want 0f 11", got[1], got[0]);
        end
    endtask

    task automatic test_overflow();
        logic [1:0][7:0] got;
        logic [7:0] fp, lp;
        int vb, gb;
        logic [1:0] go;
        drive_word({8'h80, 8'h7F}, {8'h01, 8'h01}, 2'b10, 8'h00, 0, got, fp, lp, vb, gb, go);
        tests_run++;
        if (got[0] !== 8'h80 || got[1] !== 8'h7F) begin
            fails++;
            $display("FAIL ovf_sums: got l0=%h l1=%h want 80 7f", got[0], got[1]);
        end
`ifdef SERIAL_ADDSUB_OVF_EN
        tests_run++;
        if (go !== 2'b11) begin
            fails++;
            $display("FAIL ovf_set: got %b want 11", go);
        end
`endif
        drive_word({8'h00, 8'hFF}, {8'h01, 8'h01}, 2'b10, 8'h00, 0, got, fp, lp, vb, gb, go);
        idle(1);
        tests_run++;
        if (got[0] !== 8'h00 || got[1] !== 8'hFF) begin
            fails++;
            $display("FAIL ovf_wrap: got l0=%h l1=%h want 00 ff", got[0], got[1]);
        end
`ifdef SERIAL_ADDSUB_OVF_EN
        tests_run++;
        if (go !== 2'b00) begin
            fails++;
            $display("FAIL ovf_clear: got %b want 00", go);
        end
`endif
    endtask

    task automatic test_stall();
        logic [1:0][7:0] got;
        logic [7:0] fp, lp;
        int vb, gb;
        logic [1:0] go;
        drive_word({8'h44, 8'h35}, {8'h03, 8'h0A}, 2'b10, 8'b0010_0100, 2, got, fp, lp, vb,
                   gb, go);
        idle(1);
        tests_run++;
        if (got[0] !== 8'h3F || got[1] !== 8'h41) begin
            fails++;
            $display("FAIL stall_sums: got l0=%h l1=%h want 3f 41", got[0], got[1]);
        end
        tests_run++;
        if (gb !== 0 || vb !== 0 || fp !== 8'h01 || lp !== 8'h80) begin
            fails++;
            $display("FAIL stall_flags: gap_bad=%0d vbad=%0d first=%b last=%b want 0 0 01 80",
                     gb, vb, fp, lp);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0][7:0] got1, got2;
        logic [7:0] fp, lp;
        int vb, gb;
        logic [1:0] go;
        drive_word({8'h80, 8'hFF}, {8'h01, 8'h01}, 2'b10, 8'h00, 0, got1, fp, lp, vb, gb, go);
        drive_word({8'h00, 8'h00}, {8'h00, 8'h00}, 2'b10, 8'h00, 0, got2, fp, lp, vb, gb, go);
        idle(1);
        tests_run++;
        if (got1[0] !== 8'h00 || got1[1] !== 8'h7F) begin
            fails++;
            $display("FAIL b2b_word1: got l0=%h l1=%h want 00 7f", got1[0], got1[1]);
        end
        tests_run++;
        if (got2[0] !== 8'h00 || got2[1] !== 8'h00 || fp !== 8'h01 || lp !== 8'h80) begin
            fails++;
            $display("FAIL b2b_word2: got l0=%h l1=%h first=%b last=%b want 00 00 01 80",
                     got2[0], got2[1], fp, lp);
        end
    endtask

    task automatic test_abort();
        logic [1:0][7:0] got;
        logic [7:0] fp, lp;
        int vb, gb;
        logic [1:0] go, hold;
        // Abort by clr after three bits.
        send_partial(3);
        hold     = sum;
        clr      = 1'b1;
        in_valid = 1'b1;
        x        = 2'b11;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 || sum !== hold ||
            ovf_obs !== 2'b00) begin
            fails++;
            $display("FAIL clr_outputs: v=%b f=%b l=%b sum=%b ovf=%b want 0 0 0 %b 00",
                     out_valid, out_first, out_last, sum, ovf_obs, hold);
        end
        drive_word({8'h55, 8'h12}, {8'h22, 8'h34}, 2'b10, 8'h00, 0, got, fp, lp, vb, gb, go);
        idle(1);
        tests_run++;
        if (got[0] !== 8'h46 || got[1] !== 8'h33 || fp !== 8'h01 || lp !== 8'h80) begin
            fails++;
            $display("FAIL clr_resume: got l0=%h l1=%h first=%b last=%b want 46 33 01 80",
                     got[0], got[1], fp, lp);
        end
        // Abort by asynchronous reset after three bits.
        send_partial(3);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({sum, out_valid, out_first, out_last, ovf_obs} !== '0) begin
            fails++;
            $display("FAIL rst_outputs: sum=%b v=%b f=%b l=%b ovf=%b want all 0",
                     sum, out_valid, out_first, out_last, ovf_obs);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_word({8'h55, 8'h12}, {8'h22, 8'h34}, 2'b10, 8'h00, 0, got, fp, lp, vb, gb, go);
        idle(1);
        tests_run++;
        if (got[0] !== 8'h46 || got[1] !== 8'h33 || fp !== 8'h01 || lp !== 8'h80) begin
            fails++;
            $display("FAIL rst_resume: got l0=%h l1=%h first=%b last=%b want 46 33 01 80",
                     got[0], got[1], fp, lp);
        end
    endtask

    task automatic test_random();
        logic [1:0][7:0] a, b, got;
        logic [1:0] s, go;
        logic [7:0] fp, lp, exp;
        int vb, gb, glen;
        for (int n = 0; n < 40; n++) begin
            a    = 16'($urandom);
            b    = 16'($urandom);
            s    = 2'($urandom);
            glen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            drive_word(a, b, s, 8'($urandom), glen, got, fp, lp, vb, gb, go);
            for (int l = 0; l < 2; l++) begin
                exp = ref_res(a[l], b[l], s[l]);
                tests_run++;
                if (got[l] !== exp) begin
                    fails++;
                    $display("FAIL rand_sum[%0d] lane%0d: %h %s %h got %h want %h", n, l,
                             a[l], s[l] ? "-" : "+", b[l], got[l], exp);
                end
`ifdef SERIAL_ADDSUB_OVF_EN
                tests_run++;
                if (go[l] !== ref_ovf(a[l], b[l], s[l])) begin
                    fails++;
                    $display("FAIL rand_ovf[%0d] lane%0d: got %b want %b", n, l, go[l],
                             ref_ovf(a[l], b[l], s[l]));
                end
`endif
            end
            tests_run++;
            if (fp !== 8'h01 || lp !== 8'h80 || vb !== 0 || gb !== 0) begin
                fails++;
                $display("FAIL rand_flags[%0d]: first=%b last=%b vbad=%0d gap_bad=%0d", n, fp,
                         lp, vb, gb);
            end
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_stall();
        test_back_to_back();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/serial_addsub_array.md
# serial_addsub_array

Multi-channel bit-serial adder/subtractor operating on LSB-first two's-complement words of fixed length. Each channel holds one carry flip-flop and a per-word add/subtract mode. A shared bit counter frames words and stalls on `in_valid`. The block sits in the serial arithmetic datapath as the generalised accumulate/compare stage feeding the serial-parallel multiplier and its post-processing.

## Interface
- `CHANNELS`, default 4: number of independent serial lanes (≥1).
- `WORD_W`, default 16: bits per word (≥2).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr`  in  1  synchronous framing clear.
- `in_valid`  in  1  qualifies `x`, `y` and `sub` for this cycle.
- `x`  in  CHANNELS  operand A bit per lane, LSB first.
- `y`  in  CHANNELS  operand B bit per lane, LSB first.
- `sub`  in  CHANNELS  per-lane mode, sampled only on bit 0 of a word: 1 = x−y, 0 = x+y.
- `sum`  out  CHANNELS  result bit per lane, registered.
- `out_valid`  out  1  `sum` carries a valid bit.
- `out_first`  out  1  `sum` carries bit 0 of a word.
- `out_last`  out  1  `sum` carries bit WORD_W−1 of a word.
- `ovf`  out  CHANNELS  signed overflow per lane; present only with `SERIAL_ADDSUB_OVF_EN`.

## Operation
- Bit counter `cnt` ranges 0..WORD_W−1, width $clog2(WORD_W). It advances only on accepted bits (`in_valid`=1) and wraps WORD_W−1→0.
- Bit 0 (`cnt`==0, accepted), per lane:
  - Latch `mode`←`sub`.
  - Carry-in = `sub`. The previous word's carry is discarded.
- Bits 1..WORD_W−1: carry-in = the lane's carry register. `mode` is held.
- Per accepted bit:
  - `y'` = `y` XOR active mode, where active mode is `sub` on bit 0 and `mode` otherwise.
  - `sum`←x^y'^cin.
  - carry←majority(x,y',cin).
- `in_valid`=0: counter, carries, mode and `sum` hold. `out_valid`/`out_first`/`out_last` go to 0.
- `clr`=1: has priority over `in_valid`. Next cycle: `cnt`=0, all carries/mode=0, `out_*`=0, `sum` holds. The input bit presented in the `clr` cycle is dropped.
- Reset values: `sum`=0, `out_valid`=0, `out_first`=0, `out_last`=0, `ovf`=0; internal `cnt`, carries and mode are 0.
- Reset or `clr` mid-word discards the partial word. The next accepted bit is bit 0.
- Unsigned carry-out of the MSB is not exported. Result is modulo 2^WORD_W.

## Timing
- Latency is 1 cycle: a bit accepted at edge N appears on `sum` after edge N with `out_valid`=1.
- `out_first`/`out_last` are registered together with `sum` and reflect the `cnt` value at acceptance.
- Back-to-back words need no gap. Bit 0 of word k+1 may follow bit WORD_W−1 of word k on the next cycle.
- No backpressure: the consumer must accept every `out_valid` bit.

## Configuration
- `SERIAL_ADDSUB_OVF_EN` defined:
  - `ovf` port exists, one flop per lane.
  - On the accepted last bit, `ovf`←(carry into MSB) XOR (carry out of MSB).
  - `ovf` updates in the same cycle as `sum`/`out_last`.
  - `ovf` holds until the next accepted last bit, `clr` (→0), or reset (→0).
- Not defined: `ovf` port and logic are absent. All other behaviour is identical.

## Structure
- Package `serial_arith_pkg` holds:
  - Default `CHANNELS`/`WORD_W` constants.
  - A `bit_cnt_t` sizing helper (function returning $clog2 width).
  - A `serial_mode_e` enum (ADD=0, SUB=1).
- Sub-module `serial_addsub_slice` holds one lane: carry flop, mode flop, `sum` flop and optional `ovf` flop. Its inputs are `first`, `last`, `accept`, `clr`.
- The top holds the counter and framing flags, and generates CHANNELS slices.

## Test plan
Bench uses WORD_W=8, CHANNELS=2. Bits are LSB first.
- Add, continuous `in_valid`: lane0 0x35+0x0A → serial 0x3F. `out_first` on cycle 1 after the first bit, `out_last` 7 cycles later. With OVF_EN, `ovf`=0.
- Subtract: lane1 `sub`=1, 0x10−0x01 → 0x0F. Concurrently lane0 `sub`=0, 0x10+0x01 → 0x11. Confirms independent lanes.
- Overflow (OVF_EN): 0x7F+0x01 → 0x80, `ovf`=1. 0x80−0x01 → 0x7F, `ovf`=1. 0xFF+0x01 → 0x00, `ovf`=0.
- Stall: 0x35+0x0A with `in_valid` low for 2 cycles after bits 2 and 5 → still 0x3F. `out_valid` mirrors the gaps; `sum` holds during gaps.
- Back-to-back: 0xFF+0x01 immediately followed by 0x00+0x00 → 0x00 then 0x00. No carry leaks across the word boundary.
- Abort: assert `clr` (then separately `rst`) after 3 bits of a word, then send 0x12+0x34 → 0x46 with correct `out_first`. All outputs 0 immediately after `rst`.
